// File: rtl/gray_rx.sv
// gray_rx: Gray-coded counter sample receiver.
// Decodes each valid Gray sample to binary, classifies the step against the
// previously accepted value, and tracks lock with an UNLOCKED/LOCKED/FAULT FSM.
// Pipeline: gray_in/gray_vld are captured at edge N; decoded results, wrap/err
// and the FSM update land at edge N+1.
// Optional feature: define GRAY_RX_ERRCNT_EN to build the saturating err_cnt
// counter; without it err_cnt is tied to zero.
module gray_rx #(
  parameter int unsigned CBITS = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CBITS-1:0] gray_in,
  input  logic             gray_vld,
  output logic [CBITS-1:0] bin_out,
  output logic             bin_vld,
  output logic             wrap,
  output logic             err,
  output logic             locked,
  output logic [7:0]       err_cnt
);

  localparam int unsigned GOODW = 2;
  localparam int unsigned ECW   = 8;

  // Elaboration-time guard on the supported code width
  if (CBITS < 2 || CBITS > 32) begin : g_bad_cbits
    $error("gray_rx: CBITS must be in 2..32");
  end

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_FAULT    = 2'd2
  } state_e;

  // Input capture stage
  logic [CBITS-1:0] in_gray_q, in_gray_d;
  logic             in_vld_q,  in_vld_d;

  // Decode and step classification
  logic [CBITS-1:0] dec_c;
  logic [CBITS-1:0] prev_inc_c;
  logic             inc_c;
  logic             stall_c;
  logic             bad_c;
  logic             prev_all_ones_c;

  // FSM and datapath state
  state_e           state_q, state_d;
  logic [GOODW-1:0] good_q,  good_d;
  logic [CBITS-1:0] prev_q,  prev_d;

  // Registered outputs
  logic [CBITS-1:0] bin_out_q, bin_out_d;
  logic             bin_vld_q, bin_vld_d;
  logic             wrap_q,    wrap_d;
  logic             err_q,     err_d;
  logic             locked_q,  locked_d;

  // Capture stage next values; rst clears it so a sample seen during reset is dropped
  always_comb begin
    in_gray_d = gray_in;
    in_vld_d  = gray_vld;
  end

  // Capture stage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_gray_q <= '0;
      in_vld_q  <= 1'b0;
    end else begin
      in_gray_q <= in_gray_d;
      in_vld_q  <= in_vld_d;
    end
  end

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    dec_c = '0;
    for (int i = 0; i < int'(CBITS); i++) begin
      dec_c[i] = ^(in_gray_q >> i);
    end
  end

  // Step classification relative to the last accepted value (mod 2^CBITS)
  always_comb begin
    prev_inc_c      = prev_q + CBITS'(1);
    inc_c           = (dec_c == prev_inc_c);
    stall_c         = (dec_c == prev_q);
    bad_c           = !inc_c && !stall_c;
    prev_all_ones_c = &prev_q;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_UNLOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; only valid samples move the FSM
  always_comb begin
    state_d = state_q;
    if (in_vld_q) begin
      case (state_q)
        ST_UNLOCKED: state_d = ST_LOCKED;
        ST_LOCKED: begin
          if (bad_c) begin
            state_d = ST_FAULT;
          end
        end
        ST_FAULT: begin
          if (inc_c && (good_q == GOODW'(1))) begin
            state_d = ST_LOCKED;
          end
        end
        default: state_d = ST_UNLOCKED;
      endcase
    end
  end

  // FSM output and datapath next values
  always_comb begin
    bin_out_d = bin_out_q;
    bin_vld_d = 1'b0;
    wrap_d    = 1'b0;
    err_d     = 1'b0;
    prev_d    = prev_q;
    good_d    = good_q;
    locked_d  = (state_d == ST_LOCKED);

    if (in_vld_q) begin
      bin_out_d = dec_c;
      bin_vld_d = 1'b1;
      prev_d    = dec_c;

      case (state_q)
        ST_UNLOCKED: begin
          good_d = '0;
        end
        ST_LOCKED: begin
          if (bad_c) begin
            err_d  = 1'b1;
            good_d = '0;
          end else if (inc_c && prev_all_ones_c) begin
            wrap_d = 1'b1;
          end
        end
        ST_FAULT: begin
          if (inc_c) begin
            // Leaving FAULT resets the run so the next entry starts from zero
            good_d = (good_q == GOODW'(1)) ? '0 : good_q + GOODW'(1);
          end else if (bad_c) begin
            good_d = '0;
          end
        end
        default: begin
          good_d = '0;
        end
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_out_q <= '0;
      bin_vld_q <= 1'b0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
      prev_q    <= '0;
      good_q    <= '0;
    end else begin
      bin_out_q <= bin_out_d;
      bin_vld_q <= bin_vld_d;
      wrap_q    <= wrap_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
      prev_q    <= prev_d;
      good_q    <= good_d;
    end
  end

  assign bin_out = bin_out_q;
  assign bin_vld = bin_vld_q;
  assign wrap    = wrap_q;
  assign err     = err_q;
  assign locked  = locked_q;

`ifdef GRAY_RX_ERRCNT_EN
  logic [ECW-1:0] err_cnt_q, err_cnt_d;

  // Saturating count of err pulses
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != {ECW{1'b1}})) begin
      err_cnt_d = err_cnt_q + ECW'(1);
    end
  end

  // Error counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = ECW'(0);
`endif

endmodule

// File: doc/gray_rx.md
GRAY_RX -- requirements
Module: gray_rx

Interface
REQ-001 Parameter: CBITS, default 14, code width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: gray_in  input  CBITS  Gray-coded count sample.
REQ-005 Port: gray_vld  input  1  gray_in valid this cycle.
REQ-006 Port: bin_out  output  CBITS  decoded binary count, registered.
REQ-007 Port: bin_vld  output  1  bin_out updated this cycle; one-cycle pulse per accepted sample.
REQ-008 Port: wrap  output  1  one-cycle pulse; decoded count stepped from all-ones to zero while locked.
REQ-009 Port: err  output  1  one-cycle pulse; illegal step detected while locked.
REQ-010 Port: locked  output  1  high while the FSM is in LOCKED.
REQ-011 Port: err_cnt  output  8  saturating count of err pulses.

Function
REQ-012 Decode shall be b[CBITS-1]=g[CBITS-1] and b[i]=b[i+1]^g[i] for i=CBITS-2..0.
REQ-013 Latency: a sample with gray_vld=1 at edge N shall appear on bin_out with bin_vld=1, and any wrap/err, after edge N+1.
REQ-014 With gray_vld=0, bin_vld/wrap/err shall be 0; bin_out, locked and err_cnt shall hold.
REQ-015 A prev register shall hold the last accepted decoded value; every valid sample shall update it.
REQ-016 Step classes (mod 2^CBITS): INC = decoded==prev+1; STALL = decoded==prev; BAD = anything else.
REQ-017 FSM states: UNLOCKED, LOCKED, FAULT; reset state UNLOCKED.
REQ-018 UNLOCKED: first valid sample loads prev and moves to LOCKED; no step check, no err.
REQ-019 LOCKED: INC or STALL stays in LOCKED; BAD pulses err and moves to FAULT.
REQ-020 LOCKED: an INC from all-ones to zero shall pulse wrap with that bin_vld.
REQ-021 FAULT: a 2-bit good-step counter shall be cleared on entry; an INC increments it; STALL holds it; BAD clears it without err.
REQ-022 FAULT: the second consecutive INC shall move to LOCKED; wrap is not pulsed in FAULT.
REQ-023 err_cnt shall increment on each err pulse and saturate at 255.
REQ-024 wrap and err shall never be high in the same cycle.

Reset
REQ-025 Asserting rst shall immediately force bin_out=0, bin_vld=0, wrap=0, err=0, locked=0, err_cnt=0, prev=0 and state UNLOCKED.
REQ-026 rst shall dominate gray_vld; a sample presented while rst is high shall be discarded.
REQ-027 After rst deasserts, the first valid sample shall be treated per REQ-018.

Configuration
REQ-028 Macro GRAY_RX_ERRCNT_EN: when defined, err_cnt shall behave per REQ-023.
REQ-029 When GRAY_RX_ERRCNT_EN is undefined, the counter logic shall not exist and err_cnt shall be driven to constant 0; all other behaviour is unchanged.

Verification (CBITS=4)
REQ-030 Reset, then gray_in 0000,0001,0011,0010 valid back-to-back -> bin_out 0,1,2,3 one cycle later; locked=1 from the first bin_vld; err=0.
REQ-031 Locked at binary 14, then Gray 1000 (15) then 0000 (0) -> wrap=1 exactly with bin_out=0; err=0.
REQ-032 Locked at binary 3 (Gray 0010), then Gray 0111 (5) -> err=1 for one cycle, locked=0, err_cnt=1; then Gray 0101 (6) and 0100 (7) -> locked=1 after the second.
REQ-033 Locked at 5, repeat Gray 0111 with gray_vld gaps between samples -> bin_vld pulses only on valid cycles, no err, outputs hold in the gaps.
REQ-034 Force 300 BAD steps, re-locking between them -> err_cnt saturates at 255 with the macro defined and reads 0 throughout without it.
REQ-035 rst pulsed mid-stream while locked, with gray_vld high in the same cycle -> all outputs 0 immediately; the next valid sample relocks with no err.
